// File: rtl/lutram_readback_checker.sv
// LUTRAM readback checker: walks every address once per pass and
// compares both asynchronous read ports against a fixed pattern.
module lutram_readback_checker #(
  parameter int A_WIDTH     = 6,
  parameter int PATTERN     = 0,
  parameter int DPRA_OFFSET = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               spo_i,
  input  logic               dpo_i,
  output logic [A_WIDTH-1:0] addr_o,
  output logic [A_WIDTH-1:0] dpra_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [A_WIDTH+1:0] err_count_o,
  output logic [A_WIDTH-1:0] first_err_addr_o,
  output logic [1:0]         first_err_port_o
);

  localparam int DEPTH = 1 << A_WIDTH;
  localparam logic [A_WIDTH-1:0] OFF =
    A_WIDTH'(DPRA_OFFSET % DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [A_WIDTH+1:0] err_q, err_d;
  logic [A_WIDTH-1:0] fea_q, fea_d;
  logic [1:0]         fep_q, fep_d;

  logic [A_WIDTH-1:0] dpra;
  logic               spo_mis;
  logic               dpo_mis;
  logic               last;

  // Expected data depends only on bit 0 of the address.
  function automatic logic exp_bit(input logic b0);
    logic r;
    case (PATTERN)
      0:       r = b0;
      1:       r = ~b0;
      2:       r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Second port address wraps naturally at the address width.
  always_comb begin
    dpra    = addr_q + OFF;
    spo_mis = spo_i ^ exp_bit(addr_q[0]);
    dpo_mis = dpo_i ^ exp_bit(dpra[0]);
    last    = (addr_q == {A_WIDTH{1'b1}});
  end

  // Next-state: accept start outside READ, walk addresses in READ.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    fea_d   = fea_q;
    fep_d   = fep_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = READ;
          addr_d  = '0;
          err_d   = '0;
          fea_d   = '0;
          fep_d   = '0;
        end
      end
      READ: begin
        err_d = err_q
              + (A_WIDTH+2)'(spo_mis)
              + (A_WIDTH+2)'(dpo_mis);
        // A zero count means no mismatch yet this pass.
        if ((err_q == '0) && (spo_mis || dpo_mis)) begin
          fea_d = addr_q;
          fep_d = {dpo_mis, spo_mis};
        end
        if (last) begin
          state_d = DONE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // State and result registers, cleared immediately by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      err_q   <= '0;
      fea_q   <= '0;
      fep_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      fea_q   <= fea_d;
      fep_q   <= fep_d;
    end
  end

  // Outputs derive from registered state only.
  always_comb begin
    addr_o           = addr_q;
    dpra_o           = dpra;
    busy_o           = (state_q == READ);
    done_o           = (state_q == DONE);
    pass_o           = (state_q == DONE) && (err_q == '0);
    err_count_o      = err_q;
    first_err_addr_o = fea_q;
    first_err_port_o = fep_q;
  end

endmodule
